// File: rtl/j1_io_bridge_if.sv
// -----------------------------------------------------------------------------
// j1_io_bridge_if
// Bundles the J1 CPU I/O strobe port, the data-RAM port and the TX byte
// stream of the I/O bridge into one interface.
//
//   io_we / io_re       CPU write / read strobes
//   io_ptr              CPU I/O address (T)
//   io_wdata            CPU write data (N), from the core's io_out
//   io_rdata            read data back to the core's io_in
//   ram_we/addr/wdata   data-RAM write enable, address, write data
//   ram_rdata           data-RAM read data (synchronous RAM, 1-cycle latency)
//   tx_valid / tx_data  TX byte available / FIFO head
//   tx_ready            consumer accepts the head byte
//
// Modports: slave = bridge side, master = core/RAM/consumer side.
// -----------------------------------------------------------------------------
interface j1_io_bridge_if #(
    parameter int WIDTH = 16
);
    logic             io_we;
    logic             io_re;
    logic [WIDTH-1:0] io_ptr;
    logic [WIDTH-1:0] io_wdata;
    logic [WIDTH-1:0] io_rdata;
    logic             ram_we;
    logic [WIDTH-1:0] ram_addr;
    logic [WIDTH-1:0] ram_wdata;
    logic [WIDTH-1:0] ram_rdata;
    logic             tx_valid;
    logic [7:0]       tx_data;
    logic             tx_ready;

    modport slave (
        input  io_we, io_re, io_ptr, io_wdata,
        output io_rdata,
        output ram_we, ram_addr, ram_wdata,
        input  ram_rdata,
        output tx_valid, tx_data,
        input  tx_ready
    );

    modport master (
        output io_we, io_re, io_ptr, io_wdata,
        input  io_rdata,
        input  ram_we, ram_addr, ram_wdata,
        output ram_rdata,
        input  tx_valid, tx_data,
        output tx_ready
    );
endinterface

// File: rtl/j1_io_bridge.sv
// -----------------------------------------------------------------------------
// j1_io_bridge
// Address decoder between the J1 core I/O port, the data RAM and a small set
// of memory-mapped peripherals: a TX byte FIFO, its status word and a 32-bit
// free-running cycle counter with a coherent high-half shadow.
//
// Ports:
//   clk   rising-edge clock shared with the core
//   rst   asynchronous active-high reset
//   bus   j1_io_bridge_if.slave (CPU port, RAM port, TX stream)
//
// Map: io_ptr[15:12] == 4'hF is MMIO, everything else goes to RAM.
//   0xF000  W: push io_wdata[7:0] into TX FIFO      R: 0
//   0xF001  R: {8'b0, count[3:0], 0, ovf, full, empty}  W: wdata[2]=1 clears ovf
//   0xF002  R: counter[15:0], latches counter[31:16] into the shadow
//   0xF003  R: shadow
//   others  R: 0, writes ignored
// Read data appears in the cycle after the read strobe and holds until the
// next read.
// -----------------------------------------------------------------------------
module j1_io_bridge #(
    parameter int WIDTH    = 16,
    parameter int TX_DEPTH = 8
) (
    input  logic            clk,
    input  logic            rst,
    j1_io_bridge_if.slave   bus
);
    localparam int AW = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int CW = AW + 1;

    function automatic logic [15:0] status_word(input logic [CW-1:0] count,
                                                input logic ovf,
                                                input logic full,
                                                input logic empty);
        return {8'h00, 4'(count), 1'b0, ovf, full, empty};
    endfunction

    // ---- p0: address decode, RAM path, MMIO strobes (combinational) ----
    logic        w_sel_mmio;
    logic [11:0] w_off;
    logic        w_push_req;
    logic        w_push;
    logic        w_pop;
    logic        w_empty;
    logic        w_full;
    logic        w_ovf_set;
    logic        w_ovf_clr;
    logic        w_rd_lo;

    assign w_sel_mmio = (bus.io_ptr[15:12] == 4'hF);
    assign w_off      = bus.io_ptr[11:0];

    assign bus.ram_addr  = bus.io_ptr;
    assign bus.ram_wdata = bus.io_wdata;
    assign bus.ram_we    = bus.io_we & ~w_sel_mmio;

    logic [7:0]    r_mem [TX_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_overflow;
    logic [31:0]   r_cycle;
    logic [15:0]   r_shadow;

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CW'(TX_DEPTH));
    assign w_pop      = ~w_empty & bus.tx_ready;
    assign w_push_req = bus.io_we & w_sel_mmio & (w_off == 12'h000);
    // A push into a full FIFO still lands when the head leaves in the same cycle.
    assign w_push     = w_push_req & (~w_full | w_pop);
    assign w_ovf_set  = w_push_req & w_full & ~w_pop;
    assign w_ovf_clr  = bus.io_we & w_sel_mmio & (w_off == 12'h001) & bus.io_wdata[2];
    assign w_rd_lo    = bus.io_re & w_sel_mmio & (w_off == 12'h002);

    assign bus.tx_valid = ~w_empty;
    // Head is gated so an empty FIFO shows zero rather than a stale byte.
    assign bus.tx_data  = w_empty ? 8'h00 : r_mem[r_rd_ptr];

    // MMIO read value from current (pre-write) state.
    logic [WIDTH-1:0] w_mmio_rdata;
    always_comb begin
        w_mmio_rdata = '0;
        case (w_off)
            12'h001: w_mmio_rdata = WIDTH'(status_word(r_count, r_overflow, w_full, w_empty));
            12'h002: w_mmio_rdata = WIDTH'(r_cycle[15:0]);
            12'h003: w_mmio_rdata = WIDTH'(r_shadow);
            default: w_mmio_rdata = '0;
        endcase
    end

    // ---- p1: FIFO / counter / read-result registers ----
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= bus.io_wdata[7:0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_cycle    <= '0;
            r_shadow   <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
            // Set has priority over a same-cycle clear.
            if (w_ovf_set)      r_overflow <= 1'b1;
            else if (w_ovf_clr) r_overflow <= 1'b0;
            r_cycle <= r_cycle + 32'd1;
            if (w_rd_lo) r_shadow <= r_cycle[31:16];
        end
    end

    logic             r_src_mmio_p1;
    logic             r_ram_pend_p1;
    logic [WIDTH-1:0] r_mmio_rdata_p1;
    logic [WIDTH-1:0] r_ram_hold_p1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_src_mmio_p1   <= 1'b0;
            r_ram_pend_p1   <= 1'b0;
            r_mmio_rdata_p1 <= '0;
            r_ram_hold_p1   <= '0;
        end else begin
            r_ram_pend_p1 <= bus.io_re & ~w_sel_mmio;
            // The RAM output only lives one cycle; keep a copy so io_rdata holds.
            if (r_ram_pend_p1) r_ram_hold_p1 <= bus.ram_rdata;
            if (bus.io_re) begin
                r_src_mmio_p1   <= w_sel_mmio;
                r_mmio_rdata_p1 <= w_mmio_rdata;
            end
        end
    end

    assign bus.io_rdata = r_src_mmio_p1 ? r_mmio_rdata_p1 :
                          (r_ram_pend_p1 ? bus.ram_rdata : r_ram_hold_p1);

endmodule

// File: tb/tb_j1_io_bridge.sv
module tb_j1_io_bridge;
    localparam int WIDTH    = 16;
    localparam int TX_DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    j1_io_bridge_if #(.WIDTH(WIDTH)) bus();

    j1_io_bridge #(.WIDTH(WIDTH), .TX_DEPTH(TX_DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    // Synchronous RAM model, read-old-data on a same-address write.
    logic [15:0] ram_mem [256] = '{default: 16'h0000};
    always @(posedge clk) begin
        bus.ram_rdata <= ram_mem[bus.ram_addr[7:0]];
        if (bus.ram_we) ram_mem[bus.ram_addr[7:0]] <= bus.ram_wdata;
    end

    // Edges since reset release; equals the DUT cycle counter between edges.
    int unsigned tb_cyc;
    always @(posedge clk or posedge rst) begin
        if (rst) tb_cyc <= 0;
        else     tb_cyc <= tb_cyc + 1;
    end

    int n_chk  = 0;
    int n_fail = 0;

    function void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    logic [15:0] q_rd [$];
    logic [7:0]  q_tx [$];
    logic        rd_due = 1'b0;

    // Monitor: read results one cycle after a strobe, TX bytes on handshake.
    always @(negedge clk) begin
        if (rd_due) begin
            if (q_rd.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL io_rdata_unexpected: got 0x%0h, expected no read", bus.io_rdata);
            end else begin
                chk("io_rdata", bus.io_rdata, q_rd.pop_front());
            end
        end
        rd_due <= bus.io_re && !rst;
        if (!rst && bus.tx_valid && bus.tx_ready) begin
            if (q_tx.size() == 0) begin
                n_chk++; n_fail++;
                $display("FAIL tx_unexpected: got 0x%0h, expected no byte", bus.tx_data);
            end else begin
                chk("tx_data", bus.tx_data, q_tx.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        bus.io_ptr = a; bus.io_wdata = d; bus.io_we = 1'b1;
        #1;
        chk("ram_we_decode", bus.ram_we, a[15:12] != 4'hF);
        chk("ram_addr", bus.ram_addr, a);
        chk("ram_wdata", bus.ram_wdata, d);
        tick();
        bus.io_we = 1'b0;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        bus.io_ptr = a; bus.io_re = 1'b1;
        q_rd.push_back(e);
        tick();
        bus.io_re = 1'b0;
    endtask

    task automatic rdwr(input logic [15:0] a, input logic [15:0] d, input logic [15:0] e);
        bus.io_ptr = a; bus.io_wdata = d; bus.io_we = 1'b1; bus.io_re = 1'b1;
        q_rd.push_back(e);
        tick();
        bus.io_we = 1'b0; bus.io_re = 1'b0;
    endtask

    initial begin
        #1500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.io_we = 1'b0; bus.io_re = 1'b0; bus.io_ptr = '0; bus.io_wdata = '0;
        bus.tx_ready = 1'b0;

        // Reset behaviour
        #2;
        bus.io_ptr = 16'h0010; bus.io_we = 1'b1;
        #1;
        chk("rst_ram_we_follows", bus.ram_we, 1'b1);
        bus.io_ptr = 16'hF000;
        #1;
        chk("rst_ram_we_mmio", bus.ram_we, 1'b0);
        bus.io_we = 1'b0;
        repeat (3) tick();
        chk("rst_io_rdata", bus.io_rdata, 16'h0000);
        chk("rst_tx_valid", bus.tx_valid, 1'b0);
        chk("rst_tx_data", bus.tx_data, 8'h00);
        rst = 1'b0;
        tick();

        // RAM write then read, latency and hold
        wr(16'h0010, 16'h1234);
        rd(16'h0010, 16'h1234);
        bus.io_ptr = 16'h0020;
        tick();
        chk("ram_rdata_hold", bus.io_rdata, 16'h1234);
        wr(16'h0020, 16'hBEEF);
        rd(16'h0020, 16'hBEEF);
        rdwr(16'h0010, 16'h5555, 16'h1234);
        rd(16'h0010, 16'h5555);
        wr(16'hF005, 16'hFFFF);

        // MMIO idle state
        rd(16'hF001, 16'h0001);
        rd(16'hF000, 16'h0000);
        rd(16'hF004, 16'h0000);

        // Fill past full with the consumer stalled
        for (int i = 0; i < 9; i++) begin
            wr(16'hF000, 16'h0041 + 16'(i));
            if (i < 8) q_tx.push_back(8'h41 + 8'(i));
        end
        chk("full_tx_valid", bus.tx_valid, 1'b1);
        chk("full_tx_data", bus.tx_data, 8'h41);
        rd(16'hF001, 16'h0086);
        repeat (3) tick();
        chk("stall_tx_data_stable", bus.tx_data, 8'h41);

        // Drain, then clear overflow with a simultaneous read (pre-write status)
        bus.tx_ready = 1'b1;
        repeat (8) tick();
        bus.tx_ready = 1'b0;
        chk("drained_tx_valid", bus.tx_valid, 1'b0);
        rd(16'hF001, 16'h0005);
        rdwr(16'hF001, 16'h0004, 16'h0005);
        rd(16'hF001, 16'h0001);

        // No bypass: pushed byte appears after the push edge
        bus.io_ptr = 16'hF000; bus.io_wdata = 16'h0099; bus.io_we = 1'b1;
        #1;
        chk("nobypass_before", bus.tx_valid, 1'b0);
        tick();
        bus.io_we = 1'b0;
        chk("nobypass_after_valid", bus.tx_valid, 1'b1);
        chk("nobypass_after_data", bus.tx_data, 8'h99);
        q_tx.push_back(8'h99);
        bus.tx_ready = 1'b1;
        tick();
        bus.tx_ready = 1'b0;

        // Full FIFO with a same-cycle push and pop
        for (int i = 0; i < 8; i++) begin
            wr(16'hF000, 16'h0050 + 16'(i));
            q_tx.push_back(8'h50 + 8'(i));
        end
        bus.tx_ready = 1'b1;
        wr(16'hF000, 16'h005A);
        q_tx.push_back(8'h5A);
        bus.tx_ready = 1'b0;
        rd(16'hF001, 16'h0082);
        bus.tx_ready = 1'b1;
        repeat (8) tick();
        bus.tx_ready = 1'b0;
        rd(16'hF001, 16'h0001);

        // Cycle counter past 16 bits, coherent shadow
        while (tb_cyc < 70000) tick();
        rd(16'hF002, tb_cyc[15:0]);
        rd(16'hF003, 16'h0001);

        // Reset mid-stream
        for (int i = 0; i < 3; i++) wr(16'hF000, 16'h0061 + 16'(i));
        chk("prerst_tx_valid", bus.tx_valid, 1'b1);
        rst = 1'b1;
        #1;
        chk("midrst_tx_valid", bus.tx_valid, 1'b0);
        chk("midrst_tx_data", bus.tx_data, 8'h00);
        chk("midrst_io_rdata", bus.io_rdata, 16'h0000);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        rd(16'hF001, 16'h0001);
        rd(16'hF004, 16'h0000);
        rd(16'hF002, tb_cyc[15:0]);

        repeat (3) tick();
        chk("rd_queue_drained", q_rd.size(), 0);
        chk("tx_queue_drained", q_tx.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
